// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg
//   Shared types and constants for the two-master AHB-style bus arbiter.
//   arb_state_t  : transfer sequencer state (idle / address phase / data phase)
//   arb_owner_t  : which master owns the current transfer (0 = M0, 1 = M1)
//   ARB_TIMEOUT_DEFAULT : default data-phase wait limit before abort
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  typedef logic arb_owner_t;

  localparam arb_owner_t ARB_OWNER_M0 = 1'b0;
  localparam arb_owner_t ARB_OWNER_M1 = 1'b1;

  localparam int ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/ahb_arb_pick.sv
// ahb_arb_pick
//   Combinational winner selection between two requesters. All policy lives
//   here so the transfer sequencer does not care which policy is built.
//   Build option: AHB_ARB_ROUND_ROBIN_EN
//     defined   : on contention the master that did not win last is chosen
//     undefined : fixed priority, M0 always wins contention (i_last ignored)
//   i_req[1:0] : already-masked requests, bit 0 = M0, bit 1 = M1
//   i_last     : owner of the previous grant
//   o_valid    : at least one requester
//   o_winner   : chosen master (0 = M0, 1 = M1), meaningful when o_valid
module ahb_arb_pick (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_winner
);

  assign o_valid = |i_req;

`ifdef AHB_ARB_ROUND_ROBIN_EN
  // A lone requester wins outright; on contention the other master from last time wins.
  assign o_winner = (i_req == 2'b11) ? ~i_last : i_req[1];
`else
  logic w_unused_last;
  assign w_unused_last = i_last;
  assign o_winner      = i_req[1] & ~i_req[0];
`endif

endmodule

// File: rtl/flopenr.sv
// flopenr
//   Generic register with load enable and asynchronous active-low reset.
//   clk   : clock (posedge)
//   rst_n : asynchronous active-low reset, loads RST
//   en    : load enable; q holds when low
//   d / q : data in / registered data out (W bits)
module flopenr #(
  parameter int           W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= RST;
    else if (en) q <= d;
  end

endmodule

// File: rtl/flopr.sv
// flopr
//   Generic register with asynchronous active-low reset.
//   clk   : clock (posedge)
//   rst_n : asynchronous active-low reset, loads RST
//   d / q : data in / registered data out (W bits)
module flopr #(
  parameter int           W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST;
    else        q <= d;
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter
//   Shares one AHB-style bus between M0 (data-side memory stage) and
//   M1 (instruction fetch). Each transfer runs IDLE -> ADDR -> DATA -> IDLE;
//   a watchdog aborts data phases the slave never completes.
//   Build option: AHB_ARB_ROUND_ROBIN_EN selects round-robin arbitration
//   (otherwise fixed priority, M0 first).
//
//   Handshake: a master raises mX_req with stable mX_addr/mX_write/mX_wdata
//   and holds it until it sees mX_ready high for one cycle; that cycle ends
//   the transfer (mX_rdata valid, mX_err set on timeout). A request still
//   high during its own ready cycle is ignored, so one request is served once.
//
// Ports
//   HCLK, HRESETn              : clock, asynchronous active-low reset
//   m0_*/m1_* req,addr,write,wdata : master requests
//   m0_*/m1_* rdata,ready,err  : registered completion to each master
//   HREQUEST, HADDR, HWRITE    : address phase (zero outside ADDR)
//   HWDATA                     : data-phase write data (zero outside DATA)
//   HRDATA, HREADY             : slave response
//   o_dbg_state                : current sequencer state (arb_state_t encoding)
module ahb_master_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_write,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_write,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_err,
  output logic        HREQUEST,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  output logic [1:0]  o_dbg_state
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  arb_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_hrequest, r_hwrite;
  logic [31:0]   r_haddr, r_hwdata;
  logic          r_m0_ready, r_m1_ready, r_m0_err, r_m1_err;
  logic [31:0]   r_m0_rdata, r_m1_rdata;

  logic [31:0]   r_addr_unused_q, r_wdata;
  logic          r_write;
  arb_owner_t    r_owner;

  logic [1:0]    w_req;
  logic          w_valid, w_grant, w_last;
  arb_owner_t    w_winner;
  logic [31:0]   w_sel_addr, w_sel_wdata;
  logic          w_sel_write;

  // A master completing this cycle still has req high; drop it from arbitration.
  assign w_req = {m1_req & ~r_m1_ready, m0_req & ~r_m0_ready};

  ahb_arb_pick u_pick (
    .i_req   (w_req),
    .i_last  (w_last),
    .o_valid (w_valid),
    .o_winner(w_winner)
  );

  assign w_grant     = (r_state == ARB_IDLE) && w_valid;
  assign w_sel_addr  = w_winner ? m1_addr  : m0_addr;
  assign w_sel_write = w_winner ? m1_write : m0_write;
  assign w_sel_wdata = w_winner ? m1_wdata : m0_wdata;

`ifdef AHB_ARB_ROUND_ROBIN_EN
  // Resets to M1 so that M0 wins the first contention.
  flopenr #(.W(1), .RST(1'b1)) u_last (
    .clk(HCLK), .rst_n(HRESETn), .en(w_grant), .d(w_winner), .q(w_last)
  );
`else
  assign w_last = 1'b1;
`endif

  // Transfer context captured at grant. The address is driven on HADDR
  // directly from the grant-cycle selection, so its copy here is not read.
  flopenr #(.W(32)) u_addr (
    .clk(HCLK), .rst_n(HRESETn), .en(w_grant), .d(w_sel_addr), .q(r_addr_unused_q)
  );
  flopenr #(.W(32)) u_wdata (
    .clk(HCLK), .rst_n(HRESETn), .en(w_grant), .d(w_sel_wdata), .q(r_wdata)
  );
  flopenr #(.W(2)) u_ctl (
    .clk(HCLK), .rst_n(HRESETn), .en(w_grant),
    .d({w_sel_write, w_winner}), .q({r_write, r_owner})
  );

  // Sequencer with registered bus and completion outputs. Every output
  // defaults to zero each cycle and is set only in the state that owns it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ARB_IDLE;
      r_cnt      <= '0;
      r_hrequest <= 1'b0;
      r_haddr    <= '0;
      r_hwrite   <= 1'b0;
      r_hwdata   <= '0;
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      r_hrequest <= 1'b0;
      r_haddr    <= '0;
      r_hwrite   <= 1'b0;
      r_hwdata   <= '0;
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      case (r_state)
        ARB_IDLE: begin
          if (w_grant) begin
            r_state    <= ARB_ADDR;
            r_hrequest <= 1'b1;
            r_haddr    <= w_sel_addr;
            r_hwrite   <= w_sel_write;
          end
        end
        ARB_ADDR: begin
          r_state  <= ARB_DATA;
          r_cnt    <= '0;
          r_hwdata <= r_wdata;
        end
        ARB_DATA: begin
          if (HREADY) begin
            r_state <= ARB_IDLE;
            if (r_owner == ARB_OWNER_M1) begin
              r_m1_ready <= 1'b1;
              r_m1_rdata <= r_write ? 32'h0 : HRDATA;
            end else begin
              r_m0_ready <= 1'b1;
              r_m0_rdata <= r_write ? 32'h0 : HRDATA;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ARB_IDLE;
            if (r_owner == ARB_OWNER_M1) begin
              r_m1_ready <= 1'b1;
              r_m1_err   <= 1'b1;
            end else begin
              r_m0_ready <= 1'b1;
              r_m0_err   <= 1'b1;
            end
          end else begin
            r_hwdata <= r_wdata;
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign HREQUEST    = r_hrequest;
  assign HADDR       = r_haddr;
  assign HWRITE      = r_hwrite;
  assign HWDATA      = r_hwdata;
  assign m0_ready    = r_m0_ready;
  assign m1_ready    = r_m1_ready;
  assign m0_err      = r_m0_err;
  assign m1_err      = r_m1_err;
  assign m0_rdata    = r_m0_rdata;
  assign m1_rdata    = r_m1_rdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter
//   Directed bench: a per-cycle vector table (inputs + expected registered
//   outputs after the next rising edge), then hand sequences for watchdog
//   timeout and reset during a data phase. DUT built with TIMEOUT_CYCLES = 8.
module tb_ahb_master_arbiter;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0004;
  localparam logic [31:0] W0 = 32'hAAAA_5555;
  localparam logic [31:0] W1 = 32'h1234_5678;
  localparam logic [31:0] CF = 32'hCAFE_F00D;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] Z  = 32'h0;

  logic        HCLK, HRESETn;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready, m0_err, m1_err;
  logic        HREQUEST, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  ahb_master_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .HREQUEST(HREQUEST), .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        r0, r1, w1, hr;
    logic [31:0] rd;
    logic        hq;
    logic [31:0] ha;
    logic        hw;
    logic [31:0] hd;
    logic        k0;
    logic [31:0] d0;
    logic        k1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r0, r1, w1, hr, input logic [31:0] rd,
                              input logic hq, input logic [31:0] ha, input logic hw,
                              input logic [31:0] hd, input logic k0, input logic [31:0] d0,
                              input logic k1, input logic [31:0] d1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w1 = w1; v.hr = hr; v.rd = rd;
    v.hq = hq; v.ha = ha; v.hw = hw; v.hd = hd;
    v.k0 = k0; v.d0 = d0; v.k1 = k1; v.d1 = d1;
    return v;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hrequest"}, 32'(HREQUEST), Z);
    chk({tag, "_haddr"},    HADDR,         Z);
    chk({tag, "_hwrite"},   32'(HWRITE),   Z);
    chk({tag, "_hwdata"},   HWDATA,        Z);
    chk({tag, "_m0_ready"}, 32'(m0_ready), Z);
    chk({tag, "_m0_err"},   32'(m0_err),   Z);
    chk({tag, "_m0_rdata"}, m0_rdata,      Z);
    chk({tag, "_m1_ready"}, 32'(m1_ready), Z);
    chk({tag, "_m1_err"},   32'(m1_err),   Z);
    chk({tag, "_m1_rdata"}, m1_rdata,      Z);
    chk({tag, "_state"},    32'(dbg_state), Z);
  endtask

  task automatic apply(input int idx);
    vec_t  v;
    string t;
    v = vecs[idx];
    t = $sformatf("v%0d", idx);
    m0_req = v.r0; m1_req = v.r1; m0_write = 1'b0; m1_write = v.w1;
    HREADY = v.hr; HRDATA = v.rd;
    @(posedge HCLK); #1;
    chk({t, "_hrequest"}, 32'(HREQUEST), 32'(v.hq));
    chk({t, "_haddr"},    HADDR,         v.ha);
    chk({t, "_hwrite"},   32'(HWRITE),   32'(v.hw));
    chk({t, "_hwdata"},   HWDATA,        v.hd);
    chk({t, "_m0_ready"}, 32'(m0_ready), 32'(v.k0));
    chk({t, "_m0_err"},   32'(m0_err),   Z);
    chk({t, "_m0_rdata"}, m0_rdata,      v.d0);
    chk({t, "_m1_ready"}, 32'(m1_ready), 32'(v.k1));
    chk({t, "_m1_err"},   32'(m1_err),   Z);
    chk({t, "_m1_rdata"}, m1_rdata,      v.d1);
  endtask

  task automatic tick;
    @(posedge HCLK); #1;
  endtask

  // ---------------- main test ----------------
  initial begin
    int n;
    HRESETn = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_write = 1'b0; m1_write = 1'b0;
    m0_addr = A0; m1_addr = A1; m0_wdata = W0; m1_wdata = W1;
    HREADY = 1'b0; HRDATA = Z;

    // M0 read alone, zero wait; M0 request held into its ready cycle is ignored.
    vecs.push_back(mk(1,0,0,0,Z,  1,A0,0,Z,  0,Z,0,Z));
    vecs.push_back(mk(1,0,0,0,Z,  0,Z,0,W0,  0,Z,0,Z));
    vecs.push_back(mk(1,0,0,1,CF, 0,Z,0,Z,   1,CF,0,Z));
    vecs.push_back(mk(1,0,0,1,Z,  0,Z,0,Z,   0,Z,0,Z));
    vecs.push_back(mk(0,0,0,0,Z,  0,Z,0,Z,   0,Z,0,Z));
    // M1 write; HREADY during ADDR has no effect; write returns zero rdata.
    vecs.push_back(mk(0,1,1,0,Z,  1,A1,1,Z,  0,Z,0,Z));
    vecs.push_back(mk(0,1,1,1,DB, 0,Z,0,W1,  0,Z,0,Z));
    vecs.push_back(mk(0,1,1,1,DB, 0,Z,0,Z,   0,Z,1,Z));
    vecs.push_back(mk(0,1,1,0,Z,  0,Z,0,Z,   0,Z,0,Z));
    vecs.push_back(mk(0,0,0,0,Z,  0,Z,0,Z,   0,Z,0,Z));
    // M1 read with four HREADY-low cycles; stale HRDATA must not be captured.
    vecs.push_back(mk(0,1,0,0,Z,  1,A1,0,Z,  0,Z,0,Z));
    vecs.push_back(mk(0,1,0,0,Z,  0,Z,0,W1,  0,Z,0,Z));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,1,0,0,32'h1111_1111, 0,Z,0,W1, 0,Z,0,Z));
    vecs.push_back(mk(0,1,0,1,32'h5A5A_0F0F, 0,Z,0,Z, 0,Z,1,32'h5A5A_0F0F));
    vecs.push_back(mk(0,1,0,0,Z,  0,Z,0,Z,   0,Z,0,Z));
    // Both held high: the completing master is masked, so grants go M0, M1, M0.
    vecs.push_back(mk(1,1,0,0,Z,  1,A0,0,Z,  0,Z,0,Z));
    vecs.push_back(mk(1,1,0,0,Z,  0,Z,0,W0,  0,Z,0,Z));
    vecs.push_back(mk(1,1,0,1,32'h1, 0,Z,0,Z, 1,32'h1,0,Z));
    vecs.push_back(mk(1,1,0,0,Z,  1,A1,0,Z,  0,Z,0,Z));
    vecs.push_back(mk(1,1,0,0,Z,  0,Z,0,W1,  0,Z,0,Z));
    vecs.push_back(mk(1,1,0,1,32'h2, 0,Z,0,Z, 0,Z,1,32'h2));
    vecs.push_back(mk(1,1,0,0,Z,  1,A0,0,Z,  0,Z,0,Z));
    vecs.push_back(mk(1,1,0,0,Z,  0,Z,0,W0,  0,Z,0,Z));
    vecs.push_back(mk(1,1,0,1,32'h3, 0,Z,0,Z, 1,32'h3,0,Z));
    vecs.push_back(mk(0,0,0,0,Z,  0,Z,0,Z,   0,Z,0,Z));
    // Fresh contention after M0 was last served: policy decides.
`ifdef AHB_ARB_ROUND_ROBIN_EN
    vecs.push_back(mk(1,1,0,0,Z,  1,A1,0,Z,  0,Z,0,Z));
    vecs.push_back(mk(1,1,0,0,Z,  0,Z,0,W1,  0,Z,0,Z));
    vecs.push_back(mk(1,1,0,1,32'h4, 0,Z,0,Z, 0,Z,1,32'h4));
`else
    vecs.push_back(mk(1,1,0,0,Z,  1,A0,0,Z,  0,Z,0,Z));
    vecs.push_back(mk(1,1,0,0,Z,  0,Z,0,W0,  0,Z,0,Z));
    vecs.push_back(mk(1,1,0,1,32'h4, 0,Z,0,Z, 1,32'h4,0,Z));
`endif
    vecs.push_back(mk(0,0,0,0,Z,  0,Z,0,Z,   0,Z,0,Z));

    // Reset state
    repeat (2) @(posedge HCLK);
    #1;
    chk_all_zero("reset");
    HRESETn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(i);

    // Watchdog timeout: HREADY never rises, abort 10 cycles after grant.
    m0_req = 1'b1; m1_req = 1'b0; HREADY = 1'b0; HRDATA = 32'h7777_7777;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (m0_ready) begin
        n = c;
        break;
      end
    end
    chk("timeout_latency", 32'(n), 32'd10);
    chk("timeout_err",     32'(m0_err), 32'd1);
    chk("timeout_rdata",   m0_rdata, Z);
    chk("timeout_m1_ready", 32'(m1_ready), Z);
    m0_req = 1'b0;
    tick();
    chk("timeout_err_clear", 32'(m0_err), Z);
    chk("timeout_idle", 32'(dbg_state), Z);
    // Next request proceeds normally.
    m0_req = 1'b1;
    tick();
    chk("post_to_haddr", HADDR, A0);
    chk("post_to_hreq",  32'(HREQUEST), 32'd1);
    HREADY = 1'b1; HRDATA = 32'h600D_CAFE;
    tick();
    tick();
    chk("post_to_ready", 32'(m0_ready), 32'd1);
    chk("post_to_err",   32'(m0_err), Z);
    chk("post_to_rdata", m0_rdata, 32'h600D_CAFE);
    m0_req = 1'b0; HREADY = 1'b0;
    tick();

    // Reset during DATA of an M1 write.
    m1_req = 1'b1; m1_write = 1'b1;
    tick();
    tick();
    chk("rst_pre_hwdata", HWDATA, W1);
    #3 HRESETn = 1'b0;
    #1;
    chk_all_zero("rst_async");
    HREADY = 1'b1; HRDATA = DB;
    tick();
    chk("rst_hold_m1_ready", 32'(m1_ready), Z);
    tick();
    chk("rst_hold2_m1_ready", 32'(m1_ready), Z);
    chk("rst_hold2_hreq", 32'(HREQUEST), Z);
    m1_req = 1'b0; m1_write = 1'b0;
    HRESETn = 1'b1;
    tick();
    chk("rst_after_m1_ready", 32'(m1_ready), Z);
    // First contention after reset goes to M0.
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    chk("rst_first_haddr", HADDR, A0);
    chk("rst_first_hreq",  32'(HREQUEST), 32'd1);
    HRDATA = 32'h0000_BEEF;
    tick();
    m1_req = 1'b0;
    tick();
    chk("rst_first_m0_ready", 32'(m0_ready), 32'd1);
    chk("rst_first_m0_rdata", m0_rdata, 32'h0000_BEEF);
    chk("rst_first_m1_ready", 32'(m1_ready), Z);
    m0_req = 1'b0; HREADY = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
